// File: rtl/sc_lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR byte stream (x^8+x^6+x^5+x^4+1): HUNT/SYNC/LOCK tracking,
// per-byte error pulses and a saturating error count. Define LFSRCHECK_LOSSCOUNT_EN to add the lock-loss counter.
module sc_lfsr_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int LOSS_COUNT   = 3,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                    SC_RegSHIFTER_CLOCK_50,
    input  logic                    SC_RegSHIFTER_RESET_InHigh,
    input  logic [7:0]              SC_LfsrCHECK_data_InBUS,
    input  logic                    SC_LfsrCHECK_valid_In,
    input  logic                    SC_LfsrCHECK_clear_In,
    output logic                    SC_LfsrCHECK_locked_Out,
    output logic                    SC_LfsrCHECK_error_Out,
    output logic [ERRCNT_WIDTH-1:0] SC_LfsrCHECK_errcount_OutBUS,
    output logic [7:0]              SC_LfsrCHECK_expected_OutBUS,
`ifdef LFSRCHECK_LOSSCOUNT_EN
    output logic [7:0]              SC_LfsrCHECK_losscount_OutBUS,
`endif
    output logic [1:0]              SC_LfsrCHECK_state_OutBUS
);

    // Handshake: valid qualifies exactly one byte per high cycle; there is no backpressure,
    // and every beat with valid low leaves all state untouched (clear excepted).

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_TARGET = 4'(LOSS_COUNT);

    state_t                  stateReg, stateNext;
    logic [7:0]              predReg, predNext;
    logic [3:0]              matchReg, matchNext, matchInc;
    logic [3:0]              missReg, missNext, missInc;
    logic                    lockedReg, lockedNext;
    logic                    errorReg, errorNext;
    logic [ERRCNT_WIDTH-1:0] errCountReg, errCountNext;
    logic                    lossEvent;
    logic                    dataMatch;

    function automatic logic [7:0] lfsrNext(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign matchInc  = matchReg + 4'd1;
    assign missInc   = missReg + 4'd1;
    assign dataMatch = (SC_LfsrCHECK_data_InBUS == predReg);

    always_comb begin
        stateNext    = stateReg;
        predNext     = predReg;
        matchNext    = matchReg;
        missNext     = missReg;
        lockedNext   = lockedReg;
        errorNext    = 1'b0;
        errCountNext = errCountReg;
        lossEvent    = 1'b0;
        if (SC_LfsrCHECK_valid_In) begin
            unique case (stateReg)
                HUNT: begin
                    // 0x00 is the LFSR lock-up value and can never seed a valid sequence.
                    if (SC_LfsrCHECK_data_InBUS != 8'h00) begin
                        predNext  = lfsrNext(SC_LfsrCHECK_data_InBUS);
                        matchNext = 4'd0;
                        stateNext = SYNC;
                    end
                end
                SYNC: begin
                    if (dataMatch) begin
                        predNext = lfsrNext(SC_LfsrCHECK_data_InBUS);
                        if (matchInc == LOCK_TARGET) begin
                            stateNext  = LOCK;
                            lockedNext = 1'b1;
                            matchNext  = 4'd0;
                            missNext   = 4'd0;
                        end else begin
                            matchNext = matchInc;
                        end
                    end else if (SC_LfsrCHECK_data_InBUS != 8'h00) begin
                        predNext  = lfsrNext(SC_LfsrCHECK_data_InBUS);
                        matchNext = 4'd0;
                    end else begin
                        stateNext = HUNT;
                        matchNext = 4'd0;
                    end
                end
                LOCK: begin
                    // Flywheel: once locked, the predictor advances on its own and ignores bad data.
                    predNext = lfsrNext(predReg);
                    if (dataMatch) begin
                        missNext = 4'd0;
                    end else begin
                        errorNext = 1'b1;
                        if (errCountReg != {ERRCNT_WIDTH{1'b1}})
                            errCountNext = errCountReg + ERRCNT_WIDTH'(1);
                        if (missInc == LOSS_TARGET) begin
                            stateNext  = HUNT;
                            lockedNext = 1'b0;
                            missNext   = 4'd0;
                            lossEvent  = 1'b1;
                        end else begin
                            missNext = missInc;
                        end
                    end
                end
                default: begin
                    stateNext  = HUNT;
                    lockedNext = 1'b0;
                end
            endcase
        end
        if (SC_LfsrCHECK_clear_In)
            errCountNext = '0;
    end

    always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
        if (SC_RegSHIFTER_RESET_InHigh) begin
            stateReg    <= HUNT;
            predReg     <= 8'h00;
            matchReg    <= 4'd0;
            missReg     <= 4'd0;
            lockedReg   <= 1'b0;
            errorReg    <= 1'b0;
            errCountReg <= '0;
        end else begin
            stateReg    <= stateNext;
            predReg     <= predNext;
            matchReg    <= matchNext;
            missReg     <= missNext;
            lockedReg   <= lockedNext;
            errorReg    <= errorNext;
            errCountReg <= errCountNext;
        end
    end

`ifdef LFSRCHECK_LOSSCOUNT_EN
    logic [7:0] lossCountReg;

    always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
        if (SC_RegSHIFTER_RESET_InHigh)
            lossCountReg <= 8'h00;
        else if (SC_LfsrCHECK_clear_In)
            lossCountReg <= 8'h00;
        else if (lossEvent && lossCountReg != 8'hFF)
            lossCountReg <= lossCountReg + 8'd1;
    end

    assign SC_LfsrCHECK_losscount_OutBUS = lossCountReg;
`else
    logic unusedLoss;
    assign unusedLoss = lossEvent;
`endif

    assign SC_LfsrCHECK_locked_Out      = lockedReg;
    assign SC_LfsrCHECK_error_Out       = errorReg;
    assign SC_LfsrCHECK_errcount_OutBUS = errCountReg;
    assign SC_LfsrCHECK_expected_OutBUS = predReg;
    assign SC_LfsrCHECK_state_OutBUS    = stateReg;

endmodule

// File: tb/tb_sc_lfsr_checker.sv
// Bench for sc_lfsr_checker: vector table on a default-parameter instance plus a
// hand-written saturation/clear sequence on a narrow-counter instance.
module tb_sc_lfsr_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        m_rst = 1'b0, m_valid = 1'b0, m_clr = 1'b0;
    logic [7:0]  m_data = 8'h00;
    logic        m_locked, m_err;
    logic [15:0] m_cnt;
    logic [7:0]  m_exp;
    logic [1:0]  m_st;

    logic        s_rst = 1'b1, s_valid = 1'b0, s_clr = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_locked, s_err;
    logic [3:0]  s_cnt;
    logic [7:0]  s_exp;
    logic [1:0]  s_st;

`ifdef LFSRCHECK_LOSSCOUNT_EN
    logic [7:0]  m_loss, s_loss;
`endif

    sc_lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERRCNT_WIDTH(16)) dut (
        .SC_RegSHIFTER_CLOCK_50      (clk),
        .SC_RegSHIFTER_RESET_InHigh  (m_rst),
        .SC_LfsrCHECK_data_InBUS     (m_data),
        .SC_LfsrCHECK_valid_In       (m_valid),
        .SC_LfsrCHECK_clear_In       (m_clr),
        .SC_LfsrCHECK_locked_Out     (m_locked),
        .SC_LfsrCHECK_error_Out      (m_err),
        .SC_LfsrCHECK_errcount_OutBUS(m_cnt),
        .SC_LfsrCHECK_expected_OutBUS(m_exp),
`ifdef LFSRCHECK_LOSSCOUNT_EN
        .SC_LfsrCHECK_losscount_OutBUS(m_loss),
`endif
        .SC_LfsrCHECK_state_OutBUS   (m_st)
    );

    sc_lfsr_checker #(.LOCK_COUNT(1), .LOSS_COUNT(15), .ERRCNT_WIDTH(4)) dut_sat (
        .SC_RegSHIFTER_CLOCK_50      (clk),
        .SC_RegSHIFTER_RESET_InHigh  (s_rst),
        .SC_LfsrCHECK_data_InBUS     (s_data),
        .SC_LfsrCHECK_valid_In       (s_valid),
        .SC_LfsrCHECK_clear_In       (s_clr),
        .SC_LfsrCHECK_locked_Out     (s_locked),
        .SC_LfsrCHECK_error_Out      (s_err),
        .SC_LfsrCHECK_errcount_OutBUS(s_cnt),
        .SC_LfsrCHECK_expected_OutBUS(s_exp),
`ifdef LFSRCHECK_LOSSCOUNT_EN
        .SC_LfsrCHECK_losscount_OutBUS(s_loss),
`endif
        .SC_LfsrCHECK_state_OutBUS   (s_st)
    );

    // ---------------- scoreboard ----------------
    // record layout: {locked, error, errcount[15:0], expected[7:0], state[1:0], losscount[7:0]}
    localparam int W = 36;
    logic [W-1:0] exp_q[$];
    int tests = 0;
    int failures = 0;

    function automatic logic [W-1:0] pack_exp(int l, int e, int n, int x, int s, int ls);
        logic [7:0] loss;
`ifdef LFSRCHECK_LOSSCOUNT_EN
        loss = 8'(ls);
`else
        loss = (ls > 1000) ? 8'hFF : 8'h00;
`endif
        return {1'(l), 1'(e), 16'(n), 8'(x), 2'(s), loss};
    endfunction

    function automatic logic [W-1:0] sample_main();
        logic [7:0] loss;
`ifdef LFSRCHECK_LOSSCOUNT_EN
        loss = m_loss;
`else
        loss = 8'h00;
`endif
        return {m_locked, m_err, m_cnt, m_exp, m_st, loss};
    endfunction

    function automatic logic [W-1:0] sample_sat();
        logic [7:0] loss;
`ifdef LFSRCHECK_LOSSCOUNT_EN
        loss = s_loss;
`else
        loss = 8'h00;
`endif
        return {s_locked, s_err, 12'h000, s_cnt, s_exp, s_st, loss};
    endfunction

    task automatic check(input string tag, input string field, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s %s: got %0h expected %0h", tag, field, act, expv);
        end
    endtask

    task automatic score(input string tag, input logic [W-1:0] act);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            failures++;
            $display("FAIL %s: no expected entry queued", tag);
            return;
        end
        e = exp_q.pop_front();
        check(tag, "locked",    16'(act[35]),    16'(e[35]));
        check(tag, "error",     16'(act[34]),    16'(e[34]));
        check(tag, "errcount",  act[33:18],      e[33:18]);
        check(tag, "expected",  16'(act[17:10]), 16'(e[17:10]));
        check(tag, "state",     16'(act[9:8]),   16'(e[9:8]));
        check(tag, "losscount", 16'(act[7:0]),   16'(e[7:0]));
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        pre_rst;
        logic        valid;
        logic [7:0]  data;
        logic        clr;
        logic        locked;
        logic        err;
        logic [15:0] cnt;
        logic [7:0]  expv;
        logic [1:0]  st;
        logic [7:0]  loss;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int pr, int va, int d, int c, int l, int e, int n, int x, int s, int ls);
        vec_t v;
        v.pre_rst = 1'(pr); v.valid = 1'(va); v.data = 8'(d); v.clr = 1'(c);
        v.locked = 1'(l); v.err = 1'(e); v.cnt = 16'(n); v.expv = 8'(x); v.st = 2'(s); v.loss = 8'(ls);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic main_reset_check(input string tag);
        m_rst = 1'b1; m_valid = 1'b0; m_clr = 1'b0;
        #2;
        exp_q.push_back(pack_exp(0, 0, 0, 8'h00, 0, 0));
        score(tag, sample_main());
        @(negedge clk);
        m_rst = 1'b0;
    endtask

    task automatic sat_beat(input string tag, input logic [7:0] d, input logic c, input logic [W-1:0] e);
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_clr = c;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        score(tag, sample_sat());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int errs;
        logic [7:0] sp;
        logic [7:0] d;
        logic bad;

        //      rst va data  clr  lk er cnt exp    st loss
        vecs.push_back(mk(1, 1, 8'h01, 0, 0, 0, 0, 8'h02, 1, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0, 0, 0, 8'h04, 1, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0, 0, 0, 0, 8'h08, 1, 0));
        vecs.push_back(mk(0, 1, 8'h08, 0, 0, 0, 0, 8'h11, 1, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 0, 8'h23, 2, 0));
        vecs.push_back(mk(0, 1, 8'h23, 0, 1, 0, 0, 8'h47, 2, 0));
        vecs.push_back(mk(0, 1, 8'hFF, 0, 1, 1, 1, 8'h8E, 2, 0));
        vecs.push_back(mk(0, 1, 8'h8E, 0, 1, 0, 1, 8'h1C, 2, 0));
        vecs.push_back(mk(0, 0, 8'h55, 0, 1, 0, 1, 8'h1C, 2, 0));
        vecs.push_back(mk(0, 1, 8'hAA, 0, 1, 1, 2, 8'h38, 2, 0));
        vecs.push_back(mk(0, 1, 8'hAA, 0, 1, 1, 3, 8'h71, 2, 0));
        vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 1, 4, 8'hE2, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 4, 8'hE2, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'hE2, 0, 0));
        vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 8'h02, 1, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0, 0, 0, 8'h04, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 8'h04, 0, 0));
        vecs.push_back(mk(0, 1, 8'h03, 0, 0, 0, 0, 8'h06, 1, 0));
        vecs.push_back(mk(0, 1, 8'h09, 0, 0, 0, 0, 8'h13, 1, 0));
        vecs.push_back(mk(0, 1, 8'h13, 0, 0, 0, 0, 8'h27, 1, 0));
        vecs.push_back(mk(1, 1, 8'h01, 0, 0, 0, 0, 8'h02, 1, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0, 0, 0, 8'h04, 1, 0));
        vecs.push_back(mk(1, 1, 8'h1C, 0, 0, 0, 0, 8'h38, 1, 0));
        vecs.push_back(mk(0, 1, 8'h38, 0, 0, 0, 0, 8'h71, 1, 0));
        vecs.push_back(mk(0, 1, 8'h71, 0, 0, 0, 0, 8'hE2, 1, 0));
        vecs.push_back(mk(0, 1, 8'hE2, 0, 0, 0, 0, 8'hC4, 1, 0));
        vecs.push_back(mk(0, 1, 8'hC4, 0, 1, 0, 0, 8'h89, 2, 0));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pre_rst)
                main_reset_check($sformatf("reset_before_vec%0d", i));
            @(negedge clk);
            m_valid = vecs[i].valid;
            m_data  = vecs[i].data;
            m_clr   = vecs[i].clr;
            exp_q.push_back(pack_exp(int'(vecs[i].locked), int'(vecs[i].err), int'(vecs[i].cnt),
                                     int'(vecs[i].expv), int'(vecs[i].st), int'(vecs[i].loss)));
            @(posedge clk);
            #1;
            score($sformatf("vec%0d", i), sample_main());
        end
        @(negedge clk);
        m_valid = 1'b0;
        m_clr   = 1'b0;

        // Saturation and clear-vs-error on the 4-bit counter instance.
        s_rst = 1'b0;
        sat_beat("sat_seed", 8'h01, 1'b0, pack_exp(0, 0, 0, 8'h02, 1, 0));
        sat_beat("sat_lock", 8'h02, 1'b0, pack_exp(1, 0, 0, 8'h04, 2, 0));
        sp   = 8'h04;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            bad = (i != 10);
            d   = bad ? ((sp == 8'hAA) ? 8'h55 : 8'hAA) : sp;
            if (bad)
                errs++;
            sp = lfsr_step(sp);
            sat_beat($sformatf("sat_err%0d", i), d, 1'b0,
                     pack_exp(1, int'(bad), (errs > 15) ? 15 : errs, int'(sp), 2, 0));
        end
        d  = (sp == 8'hAA) ? 8'h55 : 8'hAA;
        sp = lfsr_step(sp);
        sat_beat("sat_clear_with_error", d, 1'b1, pack_exp(1, 1, 0, int'(sp), 2, 0));
        d  = (sp == 8'hAA) ? 8'h55 : 8'hAA;
        sp = lfsr_step(sp);
        sat_beat("sat_after_clear", d, 1'b0, pack_exp(1, 1, 1, int'(sp), 2, 0));
        @(negedge clk);
        s_valid = 1'b0;
        s_clr   = 1'b0;

        if (exp_q.size() != 0) begin
            tests++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
